// File: rtl/fp_loader_pkg.sv
// Shared definitions for the FP adder operand loader: state encoding and constants.
package fp_loader_pkg;

    localparam logic [1:0] ST_LOAD_A = 2'd0;
    localparam logic [1:0] ST_LOAD_B = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    typedef enum logic [1:0] {
        LOAD_A = ST_LOAD_A,
        LOAD_B = ST_LOAD_B,
        WAIT   = ST_WAIT,
        HOLD   = ST_HOLD
    } state_t;

    localparam logic [31:0] FP_QNAN        = 32'h7FC0_0000;
    localparam int          BYTES_PER_WORD = 4;

endpackage

// File: rtl/fp_byte_assembler.sv
// MSB-first 32-bit shift register that builds one operand from four accepted bytes.
module fp_byte_assembler
    import fp_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic [1:0]  byte_cnt,
    output logic        word_done
);

    // Pulses on the transfer that completes the word so the FSM can advance on the same edge.
    assign word_done = load && (byte_cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            word     <= 32'd0;
            byte_cnt <= 2'd0;
        end else if (load) begin
            word     <= {word[23:0], in_data};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/fp_operand_loader.sv
// Loads two byte-serial FP operands, launches the adder, and returns its sum or a timeout qNaN.
module fp_operand_loader
    import fp_loader_pkg::*;
#(
    parameter int MIN_LAT = 10,
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        add,
    input  logic        done,
    input  logic [31:0] sum,
    output logic [31:0] result,
    output logic        result_valid,
    input  logic        result_ack,
    output logic        timeout_err,
    output logic        busy
);

    localparam logic [7:0] MIN_LAT_C    = 8'(MIN_LAT);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] lat_cnt;
    logic [1:0] a_cnt;
    logic [1:0] b_cnt;
    logic       a_done;
    logic       b_done;
    logic       a_load;
    logic       b_load;

    // Held low while reset is asserted so no byte is consumed in the reset cycle.
    assign in_ready = reset && ((state == LOAD_A) || (state == LOAD_B));
    assign a_load   = in_ready && in_valid && (state == LOAD_A);
    assign b_load   = in_ready && in_valid && (state == LOAD_B);

    fp_byte_assembler u_asm_a (
        .clock     (clock),
        .reset     (reset),
        .load      (a_load),
        .in_data   (in_data),
        .word      (op_a),
        .byte_cnt  (a_cnt),
        .word_done (a_done)
    );

    fp_byte_assembler u_asm_b (
        .clock     (clock),
        .reset     (reset),
        .load      (b_load),
        .in_data   (in_data),
        .word      (op_b),
        .byte_cnt  (b_cnt),
        .word_done (b_done)
    );

    // busy is registered from the next state so it equals "not idle in LOAD_A" every cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= LOAD_A;
            lat_cnt      <= 8'd0;
            add          <= 1'b0;
            result       <= 32'd0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    busy <= a_load || (a_cnt != 2'd0);
                    if (a_done) begin
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    busy <= 1'b1;
                    if (b_done) begin
                        state   <= WAIT;
                        add     <= 1'b1;
                        lat_cnt <= 8'd0;
                    end
                end
                WAIT: begin
                    busy <= 1'b1;
                    if (lat_cnt != 8'hFF) begin
                        lat_cnt <= lat_cnt + 8'd1;
                    end
                    // A done seen inside the mask window is treated as stale from a previous operation.
                    if (done && (lat_cnt >= MIN_LAT_C)) begin
                        result       <= sum;
                        add          <= 1'b0;
                        result_valid <= 1'b1;
                        timeout_err  <= 1'b0;
                        state        <= HOLD;
                    end else if (lat_cnt == TIMEOUT_LAST) begin
                        result       <= FP_QNAN;
                        add          <= 1'b0;
                        result_valid <= 1'b1;
                        timeout_err  <= 1'b1;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    busy <= !result_ack || (a_cnt != 2'd0) || (b_cnt != 2'd0);
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        timeout_err  <= 1'b0;
                        state        <= LOAD_A;
                    end
                end
                default: begin
                    state <= LOAD_A;
                end
            endcase
        end
    end

endmodule
